// File: rtl/uart_mmio_responder_pkg.sv
// Shared definitions for the UART MMIO responder: register offsets,
// STATUS/CTRL bit positions and the TX/RX line FSM encodings.
package uart_mmio_responder_pkg;

  localparam logic [31:0] REG_RXDATA = 32'h0;
  localparam logic [31:0] REG_TXDATA = 32'h4;
  localparam logic [31:0] REG_STATUS = 32'h8;
  localparam logic [31:0] REG_CTRL   = 32'hC;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_TX_IDLE     = 2;
  localparam int ST_RXOVR       = 3;
  localparam int ST_TXDROP      = 4;
  localparam int ST_FRMERR      = 5;

  localparam int CTRL_RX_IRQ_EN = 0;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous 8-bit FIFO, head visible combinationally on pop_dat_o.
// Full/empty come from registered count; a push while full is dropped even with a same-cycle pop.
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               push_dat_i,
  input  logic                     pop_i,
  output logic [7:0]               pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign push_ok   = push_i & ~full_o;
  assign pop_ok    = pop_i & ~empty_o;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// Memory-mapped 8N1 UART: four registers at BASE_ADDR, TX/RX byte FIFOs, RX-pending interrupt.
// Reads return one cycle after rden_i; TX writes to a full FIFO and RX bytes into a full FIFO are dropped and flagged.
module uart_mmio_responder
  import uart_mmio_responder_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [31:0] addr_32b_i,
  input  logic        wren_i,
  input  logic        rden_i,
  input  logic [31:0] din_32b_i,
  output logic [31:0] dout_32b_o,
  output logic        dout_32b_valid_o,
  output logic        interrupt_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i
);
  localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD;
  localparam int unsigned CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam int unsigned FCW       = $clog2(FIFO_DEPTH) + 1;

  logic hit_rx, hit_tx, hit_st, hit_ct;
  assign hit_rx = (addr_32b_i == BASE_ADDR + REG_RXDATA);
  assign hit_tx = (addr_32b_i == BASE_ADDR + REG_TXDATA);
  assign hit_st = (addr_32b_i == BASE_ADDR + REG_STATUS);
  assign hit_ct = (addr_32b_i == BASE_ADDR + REG_CTRL);

  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic           rx_push, rx_pop, rx_full, rx_empty, rx_frm_err;
  logic [7:0]     tx_head, rx_head;
  logic [FCW-1:0] tx_count, rx_count;

  tx_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_line_q, tx_line_d;

  rx_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_sync_q;

  logic [31:0] dout_q, rd_dat, status;
  logic        dout_vld_q, irq_q;
  logic        ctrl_q, ctrl_d;
  logic        rxovr_q, rxovr_d, txdrop_q, txdrop_d, frmerr_q, frmerr_d;
  logic        tx_idle, rx_nonempty, rx_bit, rx_fall;
  logic        unused_din;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .sys_clk(sys_clk), .rst_n(rst_n), .push_i(tx_push), .push_dat_i(din_32b_i[7:0]),
    .pop_i(tx_pop), .pop_dat_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .sys_clk(sys_clk), .rst_n(rst_n), .push_i(rx_push), .push_dat_i(rx_shift_q),
    .pop_i(rx_pop), .pop_dat_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  assign tx_push     = wren_i & hit_tx;
  assign rx_pop      = rden_i & hit_rx;
  assign tx_idle     = (tx_count == '0) && (tx_state_q == TX_IDLE);
  assign rx_nonempty = (rx_count != '0);
  assign rx_bit      = rx_sync_q[1];
  assign rx_fall     = rx_sync_q[2] & ~rx_sync_q[1];
  assign unused_din  = ^din_32b_i[31:8];

  always_comb begin
    status = '0;
    status[ST_RX_NONEMPTY] = rx_nonempty;
    status[ST_TX_FULL]     = tx_full;
    status[ST_TX_IDLE]     = tx_idle;
    status[ST_RXOVR]       = rxovr_q;
    status[ST_TXDROP]      = txdrop_q;
    status[ST_FRMERR]      = frmerr_q;
    rd_dat = '0;
    if (hit_rx && !rx_empty) rd_dat = {24'h0, rx_head};
    else if (hit_st)         rd_dat = status;
    else if (hit_ct)         rd_dat[CTRL_RX_IRQ_EN] = ctrl_q;
  end

  // Event sets win over a same-cycle write-1-clear so no error is lost.
  always_comb begin
    rxovr_d  = rxovr_q;
    txdrop_d = txdrop_q;
    frmerr_d = frmerr_q;
    ctrl_d   = ctrl_q;
    if (wren_i && hit_st) begin
      if (din_32b_i[ST_RXOVR])  rxovr_d  = 1'b0;
      if (din_32b_i[ST_TXDROP]) txdrop_d = 1'b0;
      if (din_32b_i[ST_FRMERR]) frmerr_d = 1'b0;
    end
    if (wren_i && hit_ct) ctrl_d = din_32b_i[CTRL_RX_IRQ_EN];
    if (rx_push && rx_full) rxovr_d  = 1'b1;
    if (tx_push && tx_full) txdrop_d = 1'b1;
    if (rx_frm_err)         frmerr_d = 1'b1;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_cnt_q - 1'b1;
    case (tx_state_q)
      TX_IDLE: if (!tx_empty) begin
        tx_pop = 1'b1; tx_shift_d = tx_head; tx_state_d = TX_START;
        tx_cnt_d = BIT_LAST; tx_line_d = 1'b0;
      end
      TX_START: if (tx_cnt_q == '0) begin
        tx_state_d = TX_DATA; tx_cnt_d = BIT_LAST; tx_bit_d = '0; tx_line_d = tx_shift_q[0];
      end
      TX_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = BIT_LAST;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP; tx_line_d = 1'b1;
        end else begin
          tx_shift_d = tx_shift_q >> 1; tx_bit_d = tx_bit_q + 1'b1; tx_line_d = tx_shift_q[1];
        end
      end
      TX_STOP: if (tx_cnt_q == '0) begin
        // Chain straight into the next start bit so queued frames leave no idle gap.
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_shift_d = tx_head; tx_state_d = TX_START;
          tx_cnt_d = BIT_LAST; tx_line_d = 1'b0;
        end else begin
          tx_state_d = TX_IDLE; tx_line_d = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_frm_err = 1'b0;
    if (rx_state_q != RX_IDLE) rx_cnt_d = rx_cnt_q - 1'b1;
    case (rx_state_q)
      RX_IDLE: if (rx_fall) begin
        rx_state_d = RX_START; rx_cnt_d = HALF_LAST;
      end
      RX_START: if (rx_cnt_q == '0) begin
        if (rx_bit) rx_state_d = RX_IDLE;
        else begin
          rx_state_d = RX_DATA; rx_cnt_d = BIT_LAST; rx_bit_d = '0;
        end
      end
      RX_DATA: if (rx_cnt_q == '0) begin
        rx_shift_d = {rx_bit, rx_shift_q[7:1]};
        rx_cnt_d   = BIT_LAST;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_bit_d = rx_bit_q + 1'b1;
      end
      RX_STOP: if (rx_cnt_q == '0) begin
        rx_state_d = RX_IDLE;
        rx_push    = rx_bit;
        rx_frm_err = ~rx_bit;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      irq_q      <= 1'b0;
      ctrl_q     <= 1'b1;
      rxovr_q    <= 1'b0;
      txdrop_q   <= 1'b0;
      frmerr_q   <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      rx_sync_q  <= 3'b111;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      dout_vld_q <= rden_i;
      if (rden_i) dout_q <= rd_dat;
      irq_q      <= rx_nonempty & ctrl_q;
      ctrl_q     <= ctrl_d;
      rxovr_q    <= rxovr_d;
      txdrop_q   <= txdrop_d;
      frmerr_q   <= frmerr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      rx_sync_q  <= {rx_sync_q[1:0], uart_rx_i};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign dout_32b_o       = dout_q;
  assign dout_32b_valid_o = dout_vld_q;
  assign interrupt_o      = irq_q;
  assign uart_tx_o        = tx_line_q;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed bench for uart_mmio_responder at a 16-cycle bit time; inputs driven and outputs sampled on the falling clock edge.
module tb_uart_mmio_responder;
  localparam int          DIV  = 16;
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [31:0] A_RX = BASE + 32'h0;
  localparam logic [31:0] A_TX = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'h8;
  localparam logic [31:0] A_CT = BASE + 32'hC;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [31:0] addr_32b_i = '0;
  logic        wren_i = 1'b0;
  logic        rden_i = 1'b0;
  logic [31:0] din_32b_i = '0;
  logic [31:0] dout_32b_o;
  logic        dout_32b_valid_o;
  logic        interrupt_o;
  logic        uart_tx_o;
  logic        uart_rx_i = 1'b1;

  int checks = 0;
  int passes = 0;

  always #5 sys_clk = ~sys_clk;

  uart_mmio_responder #(
    .CLK_FREQ(DIV * 100_000), .BAUD(100_000), .FIFO_DEPTH(16), .BASE_ADDR(BASE)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .addr_32b_i(addr_32b_i), .wren_i(wren_i),
    .rden_i(rden_i), .din_32b_i(din_32b_i), .dout_32b_o(dout_32b_o),
    .dout_32b_valid_o(dout_32b_valid_o), .interrupt_o(interrupt_o),
    .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i)
  );

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    addr_32b_i = a; din_32b_i = d; wren_i = 1'b1;
    @(negedge sys_clk);
    wren_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    @(negedge sys_clk);
    addr_32b_i = a; rden_i = 1'b1;
    @(negedge sys_clk);
    rden_i = 1'b0;
    d = dout_32b_o; v = dout_32b_valid_o;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      uart_rx_i = fr[i];
      repeat (DIV - 1) @(negedge sys_clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    rst_n = 1'b0;
    idle_cycles(3);
    checks++; if (dout_32b_o !== 32'h0) $display("FAIL reset_dout: got %h want 0", dout_32b_o); else passes++;
    checks++; if (dout_32b_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", dout_32b_valid_o); else passes++;
    checks++; if (interrupt_o !== 1'b0) $display("FAIL reset_irq: got %b want 0", interrupt_o); else passes++;
    checks++; if (uart_tx_o !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx_o); else passes++;
    @(negedge sys_clk);
    rst_n = 1'b1;
    bus_read(A_ST, d, v);
    checks++; if (d !== 32'h4 || v !== 1'b1) $display("FAIL reset_status: got %h/%b want 00000004/1", d, v); else passes++;
    bus_read(A_CT, d, v);
    checks++; if (d !== 32'h1) $display("FAIL reset_ctrl: got %h want 00000001", d); else passes++;
  endtask

  task automatic test_tx_frame();
    logic [31:0] d; logic v; logic [7:0] got; int lowcnt;
    bus_write(A_TX, 32'h41);
    checks++; if (uart_tx_o !== 1'b1) $display("FAIL tx_pre_start: got %b want 1", uart_tx_o); else passes++;
    @(negedge sys_clk);
    checks++; if (uart_tx_o !== 1'b0) $display("FAIL tx_fall_2cyc: got %b want 0", uart_tx_o); else passes++;
    lowcnt = 0;
    while (uart_tx_o === 1'b0 && lowcnt < 100) begin
      lowcnt++;
      @(negedge sys_clk);
    end
    checks++; if (lowcnt != DIV) $display("FAIL tx_start_len: got %0d want %0d", lowcnt, DIV); else passes++;
    idle_cycles(DIV / 2);
    for (int i = 0; i < 8; i++) begin
      got[i] = uart_tx_o;
      idle_cycles(DIV);
    end
    checks++; if (got !== 8'h41) $display("FAIL tx_data_bits: got %h want 41", got); else passes++;
    checks++; if (uart_tx_o !== 1'b1) $display("FAIL tx_stop_bit: got %b want 1", uart_tx_o); else passes++;
    idle_cycles(DIV);
    bus_read(A_ST, d, v);
    checks++; if (d !== 32'h4) $display("FAIL tx_idle_after: got %h want 00000004", d); else passes++;
  endtask

  task automatic test_rx_read();
    logic [31:0] d; logic v; logic irq_at_valid;
    send_rx(8'h0D, 1'b1);
    idle_cycles(2);
    checks++; if (interrupt_o !== 1'b1) $display("FAIL rx_irq_set: got %b want 1", interrupt_o); else passes++;
    bus_read(A_RX, d, v);
    irq_at_valid = interrupt_o;
    checks++; if (d !== 32'h0000_000D || v !== 1'b1) $display("FAIL rx_read_data: got %h/%b want 0000000d/1", d, v); else passes++;
    checks++; if (irq_at_valid !== 1'b1) $display("FAIL rx_irq_hold: got %b want 1", irq_at_valid); else passes++;
    @(negedge sys_clk);
    checks++; if (interrupt_o !== 1'b0) $display("FAIL rx_irq_drop: got %b want 0", interrupt_o); else passes++;
    checks++; if (dout_32b_valid_o !== 1'b0) $display("FAIL valid_one_cycle: got %b want 0", dout_32b_valid_o); else passes++;
  endtask

  // 18 back-to-back writes: the first is taken by the idle transmitter, 16 fill the FIFO, the 18th is dropped.
  task automatic test_tx_overflow();
    logic [31:0] d; logic v; logic [7:0] cur, exp_b;
    logic [7:0] rec [17];
    int bad, c, f, b;
    bad = 0; cur = '0;
    for (int n = 0; n < 2 + 17 * 10 * DIV + DIV; n++) begin
      @(negedge sys_clk);
      if (n >= 2 && ((n - 2) % DIV) == DIV / 2) begin
        c = n - 2; f = c / (10 * DIV); b = (c / DIV) % 10;
        if (f == 17) begin
          if (uart_tx_o !== 1'b1) bad++;
        end else if (b == 0) begin
          if (uart_tx_o !== 1'b0) bad++;
        end else if (b == 9) begin
          if (uart_tx_o !== 1'b1) bad++;
          rec[f] = cur;
        end else begin
          cur[b - 1] = uart_tx_o;
        end
      end
      wren_i = (n < 18); addr_32b_i = A_TX; din_32b_i = 32'h30 + n;
    end
    wren_i = 1'b0;
    checks++; if (bad != 0) $display("FAIL tx_contiguous_framing: got %0d bad samples want 0", bad); else passes++;
    for (int i = 0; i < 17; i++) begin
      exp_b = 8'h30 + 8'(i);
      checks++; if (rec[i] !== exp_b) $display("FAIL tx_frame_byte[%0d]: got %h want %h", i, rec[i], exp_b); else passes++;
    end
    bus_read(A_ST, d, v);
    checks++; if (d !== 32'h14) $display("FAIL txdrop_set: got %h want 00000014", d); else passes++;
    bus_write(A_ST, 32'h10);
    bus_read(A_ST, d, v);
    checks++; if (d !== 32'h4) $display("FAIL txdrop_clear: got %h want 00000004", d); else passes++;
  endtask

  task automatic test_rx_errors();
    logic [31:0] d, exp_d; logic v; int bad;
    for (int i = 0; i < 17; i++) send_rx(8'h50 + 8'(i), 1'b1);
    idle_cycles(4);
    bus_read(A_ST, d, v);
    checks++; if (d !== 32'h0D) $display("FAIL rxovr_status: got %h want 0000000d", d); else passes++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      bus_read(A_RX, d, v);
      exp_d = 32'h50 + i;
      if (d !== exp_d || v !== 1'b1) bad++;
    end
    checks++; if (bad != 0) $display("FAIL rx_fifo_order: got %0d wrong reads want 0", bad); else passes++;
    bus_read(A_RX, d, v);
    checks++; if (d !== 32'h0 || v !== 1'b1) $display("FAIL rx_empty_read: got %h/%b want 00000000/1", d, v); else passes++;
    bus_write(A_ST, 32'h08);
    @(negedge sys_clk); uart_rx_i = 1'b0;
    idle_cycles(5);
    uart_rx_i = 1'b1;
    idle_cycles(3 * DIV);
    bus_read(A_ST, d, v);
    checks++; if (d !== 32'h4) $display("FAIL rx_glitch: got %h want 00000004", d); else passes++;
    send_rx(8'hA5, 1'b0);
    @(negedge sys_clk); uart_rx_i = 1'b1;
    idle_cycles(2 * DIV);
    bus_read(A_ST, d, v);
    checks++; if (d !== 32'h24) $display("FAIL rx_frmerr: got %h want 00000024", d); else passes++;
    bus_write(A_ST, 32'h20);
    bus_read(A_ST, d, v);
    checks++; if (d !== 32'h4) $display("FAIL frmerr_clear: got %h want 00000004", d); else passes++;
  endtask

  task automatic test_misc();
    logic [31:0] d; logic v;
    bus_read(A_CT, d, v);
    bus_read(BASE + 32'h10, d, v);
    checks++; if (d !== 32'h0 || v !== 1'b1) $display("FAIL unmapped_read: got %h/%b want 00000000/1", d, v); else passes++;
    @(negedge sys_clk);
    addr_32b_i = A_CT; din_32b_i = 32'h0; wren_i = 1'b1; rden_i = 1'b1;
    @(negedge sys_clk);
    wren_i = 1'b0; rden_i = 1'b0;
    checks++; if (dout_32b_o !== 32'h1) $display("FAIL rw_pre_write: got %h want 00000001", dout_32b_o); else passes++;
    bus_read(A_CT, d, v);
    checks++; if (d !== 32'h0) $display("FAIL ctrl_written: got %h want 00000000", d); else passes++;
    send_rx(8'h3C, 1'b1);
    idle_cycles(4);
    checks++; if (interrupt_o !== 1'b0) $display("FAIL irq_masked: got %b want 0", interrupt_o); else passes++;
    bus_read(A_ST, d, v);
    checks++; if (d !== 32'h5) $display("FAIL masked_status: got %h want 00000005", d); else passes++;
    bus_write(A_CT, 32'h1);
    @(negedge sys_clk);
    checks++; if (interrupt_o !== 1'b1) $display("FAIL irq_unmasked: got %b want 1", interrupt_o); else passes++;
    bus_read(A_RX, d, v);
    checks++; if (d !== 32'h3C) $display("FAIL masked_data: got %h want 0000003c", d); else passes++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d; logic v;
    send_rx(8'h77, 1'b1);
    idle_cycles(4);
    bus_write(A_TX, 32'h55);
    bus_write(A_TX, 32'h66);
    idle_cycles(4);
    checks++; if (uart_tx_o !== 1'b0) $display("FAIL tx_mid_frame: got %b want 0", uart_tx_o); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (uart_tx_o !== 1'b1) $display("FAIL async_reset_tx: got %b want 1", uart_tx_o); else passes++;
    checks++; if (interrupt_o !== 1'b0 || dout_32b_o !== 32'h0) $display("FAIL async_reset_outs: got irq %b dout %h want 0/0", interrupt_o, dout_32b_o); else passes++;
    @(negedge sys_clk);
    rst_n = 1'b1;
    bus_read(A_ST, d, v);
    checks++; if (d !== 32'h4) $display("FAIL post_reset_status: got %h want 00000004", d); else passes++;
    bus_read(A_RX, d, v);
    checks++; if (d !== 32'h0) $display("FAIL post_reset_rx_empty: got %h want 00000000", d); else passes++;
    idle_cycles(2 * DIV);
    checks++; if (uart_tx_o !== 1'b1) $display("FAIL post_reset_tx_quiet: got %b want 1", uart_tx_o); else passes++;
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_rx_read();
    test_tx_overflow();
    test_rx_errors();
    test_misc();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
